// File: rtl/pushbutton_pkg.sv
// Shared definitions for the push-button debounce and capture block:
// register addresses, counter width and a popcount helper.
package pushbutton_pkg;

  typedef enum logic [1:0] {
    REG_STATE   = 2'd0,
    REG_CAPTURE = 2'd1,
    REG_MASK    = 2'd2,
    REG_COUNT   = 2'd3
  } reg_addr_e;

  localparam int PRESS_COUNT_W = 16;

  function automatic logic [5:0] popcount32(input logic [31:0] v);
    logic [5:0] n;
    n = '0;
    for (int i = 0; i < 32; i++) begin
      n = n + 6'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/pushbutton_debounce_capture_bit.sv
// Single-button conditioner: synchronizer, polarity normalization,
// stability counter and debounced level with a rising-edge press pulse.
module btn_debounce_bit
  import pushbutton_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_raw_i,
  output logic stable_o,
  output logic press_o
);

  localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             meta_q;
  logic             sync_q;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Normalizing before the first flop makes the reset value mean "released",
  // so a button held through reset still needs the full sync + debounce time.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q   <= 1'b0;
      sync_q   <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      meta_q   <= btn_raw_i ^ ACTIVE_LOW;
      sync_q   <= meta_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    cnt_d    = '0;
    stable_d = stable_q;
    if (sync_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = sync_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  assign stable_o = stable_q;
  assign press_o  = stable_d & ~stable_q;

endmodule

// File: rtl/pushbutton_debounce_capture.sv
// Debounced push buttons with press capture, interrupt mask and a
// saturating press counter behind a small Avalon-MM register file.
module pushbutton_debounce_capture
  import pushbutton_pkg::*;
#(
  parameter int NUM_BTNS        = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NUM_BTNS-1:0] btn_raw,
  input  logic [1:0]          avs_address,
  input  logic                avs_read,
  input  logic                avs_write,
  input  logic [31:0]         avs_writedata,
  output logic [31:0]         avs_readdata,
  output logic                irq,
  output logic [NUM_BTNS-1:0] btn_state
);

  logic [NUM_BTNS-1:0]      stable;
  logic [NUM_BTNS-1:0]      press;
  logic [NUM_BTNS-1:0]      wr_bits;
  logic [NUM_BTNS-1:0]      capture_q, capture_d;
  logic [NUM_BTNS-1:0]      mask_q, mask_d;
  logic [PRESS_COUNT_W-1:0] count_q, count_d;
  logic [PRESS_COUNT_W-1:0] count_base;
  logic [PRESS_COUNT_W:0]   count_sum;
  logic [31:0]              rdata_q, rdata_d;
  logic                     irq_q;
  logic                     wdata_unused;

  for (genvar i = 0; i < NUM_BTNS; i++) begin : g_btn
    btn_debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .ACTIVE_LOW     (ACTIVE_LOW)
    ) u_bit (
      .clk      (clk),
      .reset_n  (reset_n),
      .btn_raw_i(btn_raw[i]),
      .stable_o (stable[i]),
      .press_o  (press[i])
    );
  end

  assign wr_bits      = avs_writedata[NUM_BTNS-1:0];
  assign wdata_unused = ^avs_writedata;

  always_comb begin
    capture_d  = capture_q;
    mask_d     = mask_q;
    rdata_d    = rdata_q;
    count_base = count_q;

    if (avs_write && avs_address == REG_CAPTURE) capture_d = capture_q & ~wr_bits;
    capture_d = capture_d | press;

    if (avs_write && avs_address == REG_MASK) mask_d = wr_bits;

    // Clear is applied first so a press on the clearing edge still counts.
    if (avs_write && avs_address == REG_COUNT) count_base = '0;
    count_sum = {1'b0, count_base} + (PRESS_COUNT_W+1)'(popcount32(32'(press)));
    count_d   = count_sum[PRESS_COUNT_W] ? '1 : count_sum[PRESS_COUNT_W-1:0];

    if (avs_read) begin
      case (avs_address)
        REG_STATE:   rdata_d = 32'(stable);
        REG_CAPTURE: rdata_d = 32'(capture_q);
        REG_MASK:    rdata_d = 32'(mask_q);
        REG_COUNT:   rdata_d = 32'(count_q);
        default:     rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      capture_q <= '0;
      mask_q    <= '0;
      count_q   <= '0;
      rdata_q   <= '0;
      irq_q     <= 1'b0;
    end else begin
      capture_q <= capture_d;
      mask_q    <= mask_d;
      count_q   <= count_d;
      rdata_q   <= rdata_d;
      irq_q     <= |(capture_q & mask_q);
    end
  end

  assign avs_readdata = rdata_q;
  assign irq          = irq_q;
  assign btn_state    = stable;

endmodule
